// File: rtl/seg_capture.sv
// Purpose: captures a multiplexed 7-segment display (optional macro SEG_CAPTURE_BLANK_EN decodes all-off as 4'hA).
// Latency: 2 + STABLE_CYCLES clocks from stable inputs to shadow capture, plus one clock to frame_valid/bcd_out.
// Backpressure: none; free-running sampler, frame_valid is a one-clock pulse and bcd_out holds between pulses.
module seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8   // expected >= 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_valid,
  output logic                    digit_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // synchronisers plus one extra stage used only for change detection
  logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NUM_DIGITS-1:0] r_dig_s1, r_dig_s2, r_dig_prev;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  w_capture;

  logic [NUM_DIGITS-1:0]   w_sel_lo;
  logic                    w_sel_valid;
  logic                    w_changed;
  logic [3:0]              w_code;
  logic                    w_bad;
  logic                    w_full;

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic                    r_fv;
  logic                    r_err;

  // w_sel_lo is one-hot on the selected digit when the select is valid
  assign w_sel_lo    = ~r_dig_s2;
  assign w_sel_valid = (w_sel_lo != '0) && ((w_sel_lo & (w_sel_lo - NUM_DIGITS'(1))) == '0);
  assign w_changed   = (r_seg_s2 != r_seg_prev) || (r_dig_s2 != r_dig_prev);
  assign w_full      = &r_seen;

  assign bcd_out     = r_bcd;
  assign frame_valid = r_fv;
  assign digit_err   = r_err;

  // two-flop synchronisers; the prev stage holds last clock's synchronised value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
      r_dig_s1   <= '1;
      r_dig_s2   <= '1;
      r_dig_prev <= '1;
    end else begin
      r_seg_s1   <= seg_n;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_dig_s1   <= dig_sel_n;
      r_dig_s2   <= r_dig_s1;
      r_dig_prev <= r_dig_s2;
    end
  end

  // state and stability counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next-state: an invalid select always wins; capture fires as the counter reaches STABLE_CYCLES
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!w_sel_valid) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = CW'(1);
        end
        SETTLE: begin
          if (w_changed) begin
            w_cnt_nxt = CW'(1);
          end else if (r_cnt >= CW'(STABLE_CYCLES - 1)) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = CW'(STABLE_CYCLES);
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (w_changed) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // segment pattern decode (GFEDCBA, active low)
  always_comb begin
    w_code = 4'hF;
    w_bad  = 1'b1;
    case (r_seg_s2)
      7'b1000000: begin w_code = 4'd0; w_bad = 1'b0; end
      7'b1111001: begin w_code = 4'd1; w_bad = 1'b0; end
      7'b0100100: begin w_code = 4'd2; w_bad = 1'b0; end
      7'b0110000: begin w_code = 4'd3; w_bad = 1'b0; end
      7'b0011001: begin w_code = 4'd4; w_bad = 1'b0; end
      7'b0010010: begin w_code = 4'd5; w_bad = 1'b0; end
      7'b0000010: begin w_code = 4'd6; w_bad = 1'b0; end
      7'b1111000: begin w_code = 4'd7; w_bad = 1'b0; end
      7'b0000000: begin w_code = 4'd8; w_bad = 1'b0; end
      7'b0011000: begin w_code = 4'd9; w_bad = 1'b0; end
`ifdef SEG_CAPTURE_BLANK_EN
      7'b1111111: begin w_code = 4'hA; w_bad = 1'b0; end
`endif
      default: begin w_code = 4'hF; w_bad = 1'b1; end
    endcase
  end

  // shadow capture, seen mask, and whole-frame publish one clock after the mask fills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_seen   <= '0;
      r_bcd    <= '0;
      r_fv     <= 1'b0;
    end else begin
      r_fv <= w_full;
      if (w_full) begin
        r_bcd <= r_shadow;
      end
      r_seen <= (w_full ? '0 : r_seen) | (w_capture ? w_sel_lo : '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_sel_lo[i]) begin
          r_shadow[4*i +: 4] <= w_code;
        end
      end
    end
  end

  // sticky error flag; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_capture && w_bad) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus random display traffic.
// Reference model works on run lengths of identical input values delayed by the synchroniser depth.
// Each cycle compares frame_valid, bcd_out and digit_err against the model.
module tb_seg_capture;

  localparam int ND = 4;
  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_n = '1;
  logic [ND-1:0] dig_sel_n = '1;
  logic          err_clr = 1'b0;
  logic [4*ND-1:0] bcd_out;
  logic          frame_valid;
  logic          digit_err;

  always #5 clk = ~clk;

  seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .err_clr     (err_clr),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .digit_err   (digit_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // digit glyphs 0..9, active low GFEDCBA
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  // model state
  logic [6:0]      m_prev_seg;
  logic [ND-1:0]   m_prev_dig;
  int              m_run;
  bit              ev_vld  [8];
  int              ev_dig  [8];
  logic [3:0]      ev_code [8];
  bit              ev_bad  [8];
  int              cyc;
  logic [ND-1:0]   m_seen;
  logic [4*ND-1:0] m_shadow;
  logic [4*ND-1:0] m_bcd;
  bit              m_fv;
  bit              m_err;
  bit              m_clr;
  int              fv_seen;

  function automatic void decode(input logic [6:0] s, output logic [3:0] code, output bit bad);
    code = 4'hF;
    bad  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (seg_tab[i] == s) begin
        code = 4'(i);
        bad  = 1'b0;
      end
    end
`ifdef SEG_CAPTURE_BLANK_EN
    if (s == 7'h7F) begin
      code = 4'hA;
      bad  = 1'b0;
    end
`endif
  endfunction

  task automatic model_reset();
    m_prev_seg = '1;
    m_prev_dig = '1;
    m_run      = 0;
    for (int i = 0; i < 8; i++) ev_vld[i] = 1'b0;
    m_seen   = '0;
    m_shadow = '0;
    m_bcd    = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
    m_clr    = 1'b0;
    cyc      = 0;
  endtask

  // apply what the model expects to happen at edge number cyc
  task automatic model_edge();
    int slot;
    slot = cyc % 8;
    m_fv = (m_seen == '1);
    if (m_fv) begin
      m_bcd  = m_shadow;
      m_seen = '0;
    end
    if (ev_vld[slot]) begin
      m_shadow[4*ev_dig[slot] +: 4] = ev_code[slot];
      m_seen[ev_dig[slot]] = 1'b1;
    end
    if (ev_vld[slot] && ev_bad[slot]) m_err = 1'b1;
    else if (m_clr)                   m_err = 1'b0;
    ev_vld[slot] = 1'b0;
  endtask

  // drive one clock of input, advance, and compare
  task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input bit clr);
    int         slot;
    int         idx;
    logic [3:0] c;
    bit         b;
    seg_n     = s;
    dig_sel_n = d;
    err_clr   = clr;
    if ($countones(~d) == 1) begin
      if (m_run > 0 && s == m_prev_seg && d == m_prev_dig) m_run++;
      else m_run = 1;
    end else begin
      m_run = 0;
    end
    m_prev_seg = s;
    m_prev_dig = d;
    slot = (cyc + 3) % 8;
    ev_vld[slot] = (m_run == SC);
    if (m_run == SC) begin
      idx = 0;
      for (int k = 0; k < ND; k++) if (!d[k]) idx = k;
      decode(s, c, b);
      ev_dig[slot]  = idx;
      ev_code[slot] = c;
      ev_bad[slot]  = b;
    end
    m_clr = clr;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
    chk("digit_err", 32'(digit_err), 32'(m_err));
    if (frame_valid) fv_seen++;
  endtask

  task automatic hold(input logic [ND-1:0] d, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, d, 1'b0);
  endtask

  task automatic do_reset(input int n);
    seg_n     = '1;
    dig_sel_n = '1;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_frame_valid", 32'(frame_valid), 32'd0);
      chk("rst_bcd_out", 32'(bcd_out), 32'd0);
      chk("rst_digit_err", 32'(digit_err), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  logic [ND-1:0] one_bit;
  logic [ND-1:0] r_d;
  logic [6:0]    r_s;

  initial begin
    do_reset(4);

    // digits 1,2,3,4 held 20 clocks each
    fv_seen = 0;
    hold(4'b1110, seg_tab[1], 20);
    hold(4'b1101, seg_tab[2], 20);
    hold(4'b1011, seg_tab[3], 20);
    hold(4'b0111, seg_tab[4], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("full_frame_count", 32'(fv_seen), 32'd1);
    chk("full_frame_bcd", 32'(bcd_out), 32'h4321);
    chk("full_frame_err", 32'(digit_err), 32'd0);

    // seg toggling faster than the stability window never captures digit 0
    fv_seen = 0;
    for (int k = 0; k < 12; k++) hold(4'b1110, (k % 2 == 1) ? seg_tab[7] : seg_tab[9], 5);
    hold(4'b1101, seg_tab[5], 20);
    hold(4'b0111, seg_tab[6], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("toggle_no_frame", 32'(fv_seen), 32'd0);

    // bad pattern on digit 2 completes the frame with F and raises the error
    hold(4'b1011, 7'b0101010, 20);
    hold(4'b1111, 7'h7F, 6);
    chk("bad_no_frame_yet", 32'(fv_seen), 32'd0);
    hold(4'b1110, seg_tab[9], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("bad_frame_count", 32'(fv_seen), 32'd1);
    chk("bad_frame_bcd", 32'(bcd_out), 32'h6F59);
    chk("bad_err_set", 32'(digit_err), 32'd1);
    step(7'h7F, 4'b1111, 1'b1);
    step(7'h7F, 4'b1111, 1'b0);
    chk("err_cleared", 32'(digit_err), 32'd0);

    // two select lines low captures nothing and leaves the mask alone
    fv_seen = 0;
    hold(4'b1110, seg_tab[3], 20);
    hold(4'b1101, seg_tab[4], 20);
    hold(4'b1100, seg_tab[8], 30);
    hold(4'b1111, 7'h7F, 10);
    hold(4'b1011, seg_tab[7], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("multi_sel_no_frame", 32'(fv_seen), 32'd0);
    hold(4'b0111, seg_tab[0], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("multi_sel_frame", 32'(fv_seen), 32'd1);
    chk("multi_sel_bcd", 32'(bcd_out), 32'h0743);

    // reset mid-frame discards the partial frame
    hold(4'b1110, seg_tab[1], 20);
    hold(4'b1101, seg_tab[1], 20);
    hold(4'b1011, seg_tab[1], 20);
    do_reset(3);
    fv_seen = 0;
    hold(4'b0111, seg_tab[8], 20);
    hold(4'b1011, seg_tab[7], 20);
    hold(4'b1101, seg_tab[6], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("post_rst_no_frame", 32'(fv_seen), 32'd0);
    hold(4'b1110, seg_tab[5], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("post_rst_frame", 32'(fv_seen), 32'd1);
    chk("post_rst_bcd", 32'(bcd_out), 32'h8765);

    // all segments off on digit 0
    fv_seen = 0;
    hold(4'b1110, 7'h7F, 20);
    hold(4'b1101, seg_tab[1], 20);
    hold(4'b1011, seg_tab[2], 20);
    hold(4'b0111, seg_tab[3], 20);
    hold(4'b1111, 7'h7F, 6);
    chk("blank_frame", 32'(fv_seen), 32'd1);
`ifdef SEG_CAPTURE_BLANK_EN
    chk("blank_bcd", 32'(bcd_out), 32'h321A);
    chk("blank_err", 32'(digit_err), 32'd0);
`else
    chk("blank_bcd", 32'(bcd_out), 32'h321F);
    chk("blank_err", 32'(digit_err), 32'd1);
`endif

    // random traffic
    one_bit = ND'(1);
    for (int r = 0; r < 120; r++) begin
      int len;
      int p;
      int q;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(9, 24));
      p = int'($urandom_range(0, 9));
      if (p < 8)       r_d = ~(one_bit << $urandom_range(0, ND - 1));
      else if (p == 8) r_d = '1;
      else             r_d = ~(ND'(3) << $urandom_range(0, ND - 2));
      q = int'($urandom_range(0, 13));
      if (q < 10)       r_s = seg_tab[q];
      else if (q == 10) r_s = 7'h7F;
      else              r_s = 7'($urandom);
      for (int i = 0; i < len; i++) step(r_s, r_d, ($urandom_range(0, 15) == 0));
    end
    hold(4'b1111, 7'h7F, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
